// File: rtl/display_src_sel.sv
`default_nettype none
// ============================================================================
// Module      : display_src_sel
// Description : Display-source selector for the 7-segment display path.
//               Picks one of N_SRC equal-width source words for the display
//               driver. Two raw push-buttons are synchronised and debounced
//               internally:
//                 - next   : advances the selected source, with wrap-around
//                 - freeze : toggles holding of the displayed value
// Ports       : clk          in   system clock, rising edge
//               reset        in   synchronous, active-high reset
//               btn_next     in   raw bouncy button, advances the source
//               btn_freeze   in   raw bouncy button, toggles freeze
//               src_flat     in   N_SRC*WIDTH, source i at [i*WIDTH +: WIDTH]
//               to_display   out  WIDTH, registered selected/frozen value
//               mode         out  SEL_W, current source index
//               frozen       out  high while the output is held
//               mode_changed out  one-cycle pulse when mode updates
// Revision    : 1.0 - initial release
// ============================================================================
module display_src_sel #(
   parameter  int WIDTH           = 32,
   parameter  int N_SRC           = 4,
   parameter  int DEBOUNCE_CYCLES = 1_000_000,
   localparam int SEL_W           = $clog2(N_SRC)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_next,
   input  logic                   btn_freeze,
   input  logic [N_SRC*WIDTH-1:0] src_flat,
   output logic [WIDTH-1:0]       to_display,
   output logic [SEL_W-1:0]       mode,
   output logic                   frozen,
   output logic                   mode_changed
);

   // A counter of at least one bit keeps DEBOUNCE_CYCLES == 1 legal.
   localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SEL_W-1:0] MODE_LAST = SEL_W'(N_SRC - 1);

   // Index 0 is the next button, index 1 the freeze button.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {btn_freeze, btn_next};

   // ------------------------------------------------------------------------
   // Per-button conditioning: 2-flop synchroniser, debounce, rising-edge pulse
   // ------------------------------------------------------------------------
   generate
      for (genvar b = 0; b < 2; b++) begin : g_btn
         logic             sync1;
         logic             s;
         logic             d;
         logic             d_q;
         logic             press_q;
         logic [CNT_W-1:0] cnt;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1   <= 1'b0;
               s       <= 1'b0;
               d       <= 1'b0;
               d_q     <= 1'b0;
               press_q <= 1'b0;
               cnt     <= '0;
            end else begin
               sync1 <= btn_raw[b];
               s     <= sync1;
               // The count only runs while the synchronised level disagrees
               // with the accepted level; any agreement restarts it, so a
               // glitch shorter than DEBOUNCE_CYCLES never reaches d.
               if (s == d) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  d   <= s;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               d_q     <= d;
               press_q <= d & ~d_q;
            end
         end

         assign press[b] = press_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Source mux: compare against every legal index so an unused encoding
   // (N_SRC not a power of two) can never address past the source vector.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] sel_val;

   always_comb begin
      sel_val = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (mode == SEL_W'(i)) begin
            sel_val = src_flat[i*WIDTH +: WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Mode, freeze and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         mode         <= '0;
         frozen       <= 1'b0;
         mode_changed <= 1'b0;
         to_display   <= '0;
      end else begin
         if (press[0]) begin
            mode         <= (mode == MODE_LAST) ? '0 : mode + 1'b1;
            mode_changed <= 1'b1;
         end else begin
            mode_changed <= 1'b0;
         end

         if (press[1]) begin
            frozen <= ~frozen;
         end

         // Uses the current frozen/mode values: a freeze press lets one more
         // sample through, and an unfreeze shows the new mode a cycle later.
         if (!frozen) begin
            to_display <= sel_val;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_src_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_src_sel
// Description : Self-checking bench for display_src_sel with a behavioural
//               reference model and a mode-change scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_src_sel;

   localparam int WIDTH = 32;
   localparam int N_SRC = 3;
   localparam int DEB   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_next = 1'b0;
   logic        btn_freeze = 1'b0;
   logic [31:0] src [N_SRC];
   logic [N_SRC*WIDTH-1:0] src_flat;
   logic [WIDTH-1:0] to_display;
   logic [1:0]  mode;
   logic        frozen;
   logic        mode_changed;

   assign src_flat = {src[2], src[1], src[0]};

   always #5 clk = ~clk;

   display_src_sel #(
      .WIDTH(WIDTH),
      .N_SRC(N_SRC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_next(btn_next),
      .btn_freeze(btn_freeze),
      .src_flat(src_flat),
      .to_display(to_display),
      .mode(mode),
      .frozen(frozen),
      .mode_changed(mode_changed)
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: a button level is accepted once its synchronised value
   // has disagreed with the accepted level for DEB consecutive cycles; each
   // accepted rise becomes one action two cycles later.
   // ------------------------------------------------------------------------
   int          m_cycle = 0;
   int          m_mode = 0;
   bit          m_frozen = 0;
   logic [31:0] m_disp = 0;
   bit          m_raw [2];
   bit          m_sync [2];
   bit          m_s [2];
   bit          m_d [2];
   bit          m_dprev [2];
   bit          m_press [2];
   int          m_run [2];
   int          exp_mode_q [$];
   int          exp_cyc_q [$];

   always @(posedge clk) begin
      m_cycle++;
      m_raw[0] = btn_next;
      m_raw[1] = btn_freeze;
      if (reset) begin
         m_mode = 0; m_frozen = 0; m_disp = 0;
         for (int b = 0; b < 2; b++) begin
            m_sync[b] = 0; m_s[b] = 0; m_d[b] = 0; m_dprev[b] = 0;
            m_press[b] = 0; m_run[b] = 0;
         end
      end else begin
         if (!m_frozen) m_disp = src[m_mode];
         if (m_press[1]) m_frozen = !m_frozen;
         if (m_press[0]) begin
            m_mode = (m_mode + 1) % N_SRC;
            exp_mode_q.push_back(m_mode);
            exp_cyc_q.push_back(m_cycle);
         end
         for (int b = 0; b < 2; b++) begin
            m_press[b] = m_d[b] && !m_dprev[b];
            m_dprev[b] = m_d[b];
            if (m_s[b] != m_d[b]) begin
               m_run[b]++;
               if (m_run[b] == DEB) begin
                  m_d[b]   = m_s[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
            m_s[b]    = m_sync[b];
            m_sync[b] = m_raw[b];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: compares registered outputs mid-cycle; pops the scoreboard on
   // each mode_changed pulse.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      chk("to_display", to_display, m_disp);
      chk("mode", 32'(mode), 32'(m_mode));
      chk("frozen", 32'(frozen), 32'(m_frozen));
      if (mode_changed) begin
         n_pulses++;
         if (exp_mode_q.size() == 0) begin
            chk("mode_changed_unexpected", 32'(mode_changed), 32'd0);
         end else begin
            chk("pulse_mode", 32'(mode), 32'(exp_mode_q.pop_front()));
            chk("pulse_cycle", 32'(m_cycle), 32'(exp_cyc_q.pop_front()));
         end
      end else if (exp_mode_q.size() != 0) begin
         chk("mode_changed_missing", 32'(mode_changed), 32'd1);
         void'(exp_mode_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raw rise to mode change is DEB+4 = 8 edges.
   task automatic press_next_timed(input int hold);
      int old;
      old = m_mode;
      btn_next = 1'b1;
      tick(7);
      chk("latency_before", 32'(mode), 32'(old));
      tick(1);
      chk("latency_after", 32'(mode), 32'((old + 1) % N_SRC));
      tick(hold - 8);
      btn_next = 1'b0;
      tick(10);
   endtask

   task automatic press_freeze(input int hold);
      btn_freeze = 1'b1;
      tick(hold);
      btn_freeze = 1'b0;
      tick(10);
   endtask

   initial begin
      logic [31:0] exp_disp [3];
      int          start_pulses;
      int          old_mode;
      bit          old_frz;
      bit          found;

      src[0] = 32'h0000_1234;
      src[1] = 32'h0000_4660;
      src[2] = 32'hDEAD_BEEF;
      exp_disp[0] = 32'h0000_4660;
      exp_disp[1] = 32'hDEAD_BEEF;
      exp_disp[2] = 32'h0000_1234;

      // 1. Reset and idle
      reset = 1'b1;
      tick(2);
      chk("reset_display", to_display, 32'h0);
      chk("reset_mode", 32'(mode), 32'd0);
      reset = 1'b0;
      tick(1);
      chk("idle_display", to_display, 32'h0000_1234);
      chk("idle_frozen", 32'(frozen), 32'd0);
      chk("idle_mode_changed", 32'(mode_changed), 32'd0);
      tick(3);

      // 2. Clean presses with wrap
      start_pulses = n_pulses;
      for (int i = 0; i < 3; i++) begin
         press_next_timed(10);
         chk("wrap_display", to_display, exp_disp[i]);
      end
      chk("wrap_pulses", 32'(n_pulses - start_pulses), 32'd3);
      chk("wrap_mode", 32'(mode), 32'd0);

      // 3. Bounce rejection: high runs of 1..3 cycles never survive debounce
      old_mode = int'(mode);
      for (int t = 0; t < 20; ) begin
         int len;
         len = int'($urandom_range(3, 1));
         btn_next = ~btn_next;
         tick(len);
         t += len;
      end
      btn_next = 1'b0;
      tick(2);
      chk("bounce_no_step", 32'(mode), 32'(old_mode));
      btn_next = 1'b1;
      tick(10);
      btn_next = 1'b0;
      tick(10);
      chk("bounce_one_step", 32'(mode), 32'((old_mode + 1) % N_SRC));

      // 4. Long hold advances once, re-press advances again
      old_mode = int'(mode);
      btn_next = 1'b1;
      tick(200);
      chk("hold_one_step", 32'(mode), 32'((old_mode + 1) % N_SRC));
      btn_next = 1'b0;
      tick(10);
      press_next_timed(10);
      chk("repress_step", 32'(mode), 32'((old_mode + 2) % N_SRC));

      // 5. Freeze
      chk("freeze_start_mode", 32'(mode), 32'd0);
      press_freeze(10);
      chk("freeze_on", 32'(frozen), 32'd1);
      chk("freeze_hold", to_display, 32'h0000_1234);
      src[0] = 32'hAAAA_AAAA;
      press_next_timed(10);
      chk("frozen_mode", 32'(mode), 32'd1);
      chk("frozen_display", to_display, 32'h0000_1234);
      press_freeze(10);
      chk("unfreeze", 32'(frozen), 32'd0);
      chk("unfreeze_display", to_display, 32'h0000_4660);

      // 6a. Simultaneous presses act on the same edge
      old_mode = int'(mode);
      old_frz  = frozen;
      found    = 1'b0;
      btn_next   = 1'b1;
      btn_freeze = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (int'(mode) != old_mode) found = 1'b1;
      end
      chk("simul_seen", 32'(found), 32'd1);
      chk("simul_frozen", 32'(frozen), 32'(!old_frz));
      btn_next   = 1'b0;
      btn_freeze = 1'b0;
      tick(12);

      // 6b. Reset mid-debounce with the button still held
      btn_next = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(2);
      chk("midreset_display", to_display, 32'h0);
      chk("midreset_mode", 32'(mode), 32'd0);
      chk("midreset_frozen", 32'(frozen), 32'd0);
      chk("midreset_pulse", 32'(mode_changed), 32'd0);
      reset = 1'b0;
      tick(7);
      chk("post_reset_before", 32'(mode), 32'd0);
      tick(1);
      chk("post_reset_after", 32'(mode), 32'd1);
      btn_next = 1'b0;
      tick(10);

      // Random phase against the model
      for (int i = 0; i < 1500; i++) begin
         btn_next   = 1'($urandom_range(1, 0));
         btn_freeze = 1'($urandom_range(1, 0));
         if ($urandom_range(9, 0) == 0) src[$urandom_range(2, 0)] = $urandom;
         if ($urandom_range(99, 0) == 0) begin
            reset = 1'b1;
            tick(int'($urandom_range(2, 1)));
            reset = 1'b0;
         end
         tick(int'($urandom_range(8, 1)));
      end
      btn_next   = 1'b0;
      btn_freeze = 1'b0;
      tick(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
